// File: rtl/trap_ctrl.sv
// trap_ctrl: M-mode trap / MRET sequencer between the pipeline and the CSR file.
// Takes an exception, an enabled pending interrupt or an MRET in IDLE, then
// walks the trap CSR writes in fixed order and issues a single fetch redirect.
// Optional build macro: MTVEC_VECTORED_EN (vectored mtvec mode for interrupts).
// MXLEN defaults to `MXLEN, which falls back to 32 when not supplied.
`ifndef MXLEN
`define MXLEN 32
`endif

module trap_ctrl #(
  parameter int MXLEN = `MXLEN
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             exc_valid,
  input  logic [4:0]       exc_code,
  input  logic [MXLEN-1:0] exc_pc,
  input  logic [MXLEN-1:0] exc_tval,
  output logic             exc_ack,
  input  logic             mret_valid,
  output logic             mret_ack,
  input  logic             irq_mei,
  input  logic             irq_msi,
  input  logic             irq_mti,
  input  logic [MXLEN-1:0] irq_pc,
  input  logic [MXLEN-1:0] mstatus_in,
  input  logic [MXLEN-1:0] mie_in,
  input  logic [MXLEN-1:0] mtvec_in,
  input  logic [MXLEN-1:0] mepc_in,
  output logic             csr_we,
  output logic [11:0]      csr_waddr,
  output logic [MXLEN-1:0] csr_wdata,
  output logic             busy,
  output logic             flush,
  output logic             redirect_valid,
  output logic [MXLEN-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_EPC    = 3'd1,
    S_W_CAUSE  = 3'd2,
    S_W_TVAL   = 3'd3,
    S_W_STATUS = 3'd4,
    S_R_STATUS = 3'd5,
    S_REDIRECT = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic             intr_q, intr_d;
  logic             mret_q, mret_d;
  logic [4:0]       code_q, code_d;
  logic [MXLEN-1:0] pc_q, pc_d;
  logic [MXLEN-1:0] tval_q, tval_d;

  logic             mei_s, msi_s, mti_s, irq_any_s;
  logic [4:0]       irq_code_s;
  logic [MXLEN-1:0] base_s, vector_s;
  logic             unused_s;

  // mstatus image on trap entry: MPIE<-MIE, MIE<-0, MPP<-M
  function automatic logic [MXLEN-1:0] trap_status(input logic [MXLEN-1:0] s);
    logic [MXLEN-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // mstatus image on MRET: MIE<-MPIE, MPIE<-1, MPP<-M
  function automatic logic [MXLEN-1:0] mret_status(input logic [MXLEN-1:0] s);
    logic [MXLEN-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  assign mei_s     = mstatus_in[3] & irq_mei & mie_in[11];
  assign msi_s     = mstatus_in[3] & irq_msi & mie_in[3];
  assign mti_s     = mstatus_in[3] & irq_mti & mie_in[7];
  assign irq_any_s = mei_s | msi_s | mti_s;
  assign base_s    = {mtvec_in[MXLEN-1:2], 2'b00};
  // Low pc/mepc bits are forced to zero, and mie only matters per enabled line.
  assign unused_s  = ^{mepc_in[1:0], pc_q[1:0], mtvec_in[1:0], mie_in};

  // Interrupt priority: external, then software, then timer
  always_comb begin
    irq_code_s = 5'd0;
    if (mei_s) begin
      irq_code_s = 5'd11;
    end else if (msi_s) begin
      irq_code_s = 5'd3;
    end else if (mti_s) begin
      irq_code_s = 5'd7;
    end else begin
      irq_code_s = 5'd0;
    end
  end

  // Trap target: direct base, or base + 4*cause for vectored interrupts
  always_comb begin
    vector_s = base_s;
`ifdef MTVEC_VECTORED_EN
    if (intr_q && (mtvec_in[1:0] == 2'b01)) begin
      vector_s = base_s + {{(MXLEN-7){1'b0}}, code_q, 2'b00};
    end else begin
      vector_s = base_s;
    end
`endif
  end

  // Next-state, accept handshake and CSR write decode
  always_comb begin
    state_d        = state_q;
    intr_d         = intr_q;
    mret_d         = mret_q;
    code_d         = code_q;
    pc_d           = pc_q;
    tval_d         = tval_q;
    exc_ack        = 1'b0;
    mret_ack       = 1'b0;
    flush          = 1'b0;
    csr_we         = 1'b0;
    csr_waddr      = 12'h000;
    csr_wdata      = {MXLEN{1'b0}};
    busy           = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = {MXLEN{1'b0}};
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        // Handshake stays quiet while reset is held so every output reads 0.
        if (!reset) begin
          state_d = S_IDLE;
        end else if (exc_valid) begin
          exc_ack = 1'b1;
          flush   = 1'b1;
          intr_d  = 1'b0;
          mret_d  = 1'b0;
          code_d  = exc_code;
          pc_d    = exc_pc;
          tval_d  = exc_tval;
          state_d = S_W_EPC;
        end else if (irq_any_s) begin
          flush   = 1'b1;
          intr_d  = 1'b1;
          mret_d  = 1'b0;
          code_d  = irq_code_s;
          pc_d    = irq_pc;
          tval_d  = {MXLEN{1'b0}};
          state_d = S_W_EPC;
        end else if (mret_valid) begin
          mret_ack = 1'b1;
          flush    = 1'b1;
          intr_d   = 1'b0;
          mret_d   = 1'b1;
          state_d  = S_R_STATUS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_W_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h341;
        csr_wdata = {pc_q[MXLEN-1:2], 2'b00};
        state_d   = S_W_CAUSE;
      end
      S_W_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h342;
        csr_wdata = {intr_q, {(MXLEN-6){1'b0}}, code_q};
        state_d   = S_W_TVAL;
      end
      S_W_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h343;
        csr_wdata = tval_q;
        state_d   = S_W_STATUS;
      end
      S_W_STATUS: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h300;
        csr_wdata = trap_status(mstatus_in);
        state_d   = S_REDIRECT;
      end
      S_R_STATUS: begin
        csr_we    = 1'b1;
        csr_waddr = 12'h300;
        csr_wdata = mret_status(mstatus_in);
        state_d   = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = mret_q ? {mepc_in[MXLEN-1:2], 2'b00} : vector_s;
        state_d        = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched trap context; reset abandons any sequence in flight
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      intr_q  <= 1'b0;
      mret_q  <= 1'b0;
      code_q  <= 5'd0;
      pc_q    <= {MXLEN{1'b0}};
      tval_q  <= {MXLEN{1'b0}};
    end else begin
      state_q <= state_d;
      intr_q  <= intr_d;
      mret_q  <= mret_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
    end
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- M-mode trap and MRET sequencer that sits between the pipeline and the CSR file.
- On an exception or a pending enabled interrupt it writes mepc, mcause, mtval and mstatus in fixed order through the CSR write port, then redirects fetch to the trap vector.
- On MRET it restores mstatus and redirects fetch to mepc.
- It is the only writer of trap CSRs and owns the pipeline flush during trap handling.

Parameters:
- MXLEN, 32, datapath width; must match `MXLEN.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- exc_valid  input  1  synchronous exception request; held until exc_ack.
- exc_code  input  5  exception code (mcause exccode).
- exc_pc  input  MXLEN  PC of the faulting instruction.
- exc_tval  input  MXLEN  value for mtval.
- exc_ack  output  1  one-cycle pulse when the exception is accepted.
- mret_valid  input  1  MRET retiring; held until mret_ack.
- mret_ack  output  1  one-cycle pulse when MRET is accepted.
- irq_mei, irq_msi, irq_mti  input  1 each  raw pending lines (mip bits 11/3/7).
- irq_pc  input  MXLEN  PC of the next unretired instruction (interrupt mepc).
- mstatus_in, mie_in, mtvec_in, mepc_in  input  MXLEN  current CSR values.
- csr_we  output  1  CSR write strobe.
- csr_waddr  output  12  CSR write address.
- csr_wdata  output  MXLEN  CSR write data.
- busy  output  1  sequence in progress.
- flush  output  1  kill in-flight instructions.
- redirect_valid  output  1  one-cycle fetch redirect.
- redirect_pc  output  MXLEN  redirect target.

Behaviour:
- Reset (reset=0, async): FSM enters IDLE. All outputs are 0, and all latched cause/pc/tval registers are 0. Asserting reset mid-sequence abandons the sequence; CSR writes already issued stand, and no further writes occur.
- Interrupt pending = mstatus_in[3] & (irq_X & mie_in[bit]). Priority among interrupts: MEI(11) > MSI(3) > MTI(7).
- Arbitration in IDLE, evaluated each cycle:
  - exc_valid beats interrupt, which beats mret_valid.
  - The loser gets no ack and must hold its request.
  - No request is accepted when not in IDLE.
- Accept cycle (cycle 0):
  - The winner's ack pulses (interrupts have no ack).
  - code, is_intr, pc (exc_pc or irq_pc) and tval (exc_tval, or 0 for an interrupt) are latched.
  - flush=1 for that cycle.
  - Inputs are ignored from then until IDLE, except the CSR values named below.
- Trap states, one cycle each, csr_we=1 in each:
  - W_EPC: addr 0x341, data {pc[MXLEN-1:2],2'b00}.
  - W_CAUSE: addr 0x342, data {is_intr, zeros, code}.
  - W_TVAL: addr 0x343, data tval.
  - W_STATUS: addr 0x300, data is mstatus_in with MPIE(7)←MIE(3), MIE←0, MPP(12:11)←2'b11, other bits unchanged.
  - REDIRECT: redirect_valid=1, redirect_pc=vector, csr_we=0.
  - Then IDLE.
  - Latency: writes occur on cycles 1–4, redirect on cycle 5. busy=1 on cycles 1–5.
- MRET states:
  - R_STATUS: addr 0x300, data is mstatus_in with MIE←MPIE, MPIE←1, MPP←2'b11.
  - REDIRECT: redirect_pc={mepc_in[MXLEN-1:2],2'b00}.
  - Writes on cycle 1, redirect on cycle 2.
- Vector: base={mtvec_in[MXLEN-1:2],2'b00}. Mode bits ignored unless the feature below is enabled.
- Back-to-back: an interrupt that becomes enabled after MRET is accepted no earlier than the cycle after REDIRECT.
- csr_waddr and csr_wdata are 0 whenever csr_we=0.

Optional Feature:
- Macro: MTVEC_VECTORED_EN.
- Defined: if mtvec_in[1:0]==2'b01 and is_intr, redirect_pc=base+(code<<2). Exceptions always use base. Mode 2'b1x is treated as direct.
- Undefined: redirect_pc=base always; mtvec_in[1:0] is ignored.

Test Plan:
- Reset with reset=0 mid W_CAUSE → next cycle all outputs 0, FSM IDLE; a new exc_valid is accepted after reset=1.
- exc_valid, code=2, exc_pc=0x100, tval=0xDEAD, mstatus_in=0x8, mtvec_in=0x200 → ack cycle 0; writes 0x341=0x100, 0x342=0x2, 0x343=0xDEAD, 0x300=0x1880; redirect_pc=0x200 on cycle 5.
- irq_mti=irq_mei=1, mie_in=0x880, MIE=1, irq_pc=0x44 → mcause=0x8000000B, mepc=0x44; with MTVEC_VECTORED_EN and mtvec_in=0x201, redirect_pc=0x22C.
- exc_valid and mret_valid together → exc_ack only, trap sequence runs; mret_ack follows on the first IDLE cycle after REDIRECT.
- mret_valid, mstatus_in=0x1880, mepc_in=0x104 → write 0x300=0x1888 on cycle 1, redirect_pc=0x104 on cycle 2.
- irq_msi=1 with mstatus MIE=0, or mie_in[3]=0 → no activity; busy stays 0 for 20 cycles.
